// File: rtl/stage_cfg_ctrl.sv
// Per-stage config controller: closes the stage, drains PHVs in flight, writes one
// table entry (key-offset, lookup CAM or action RAM), lets it settle, then re-opens.
module stage_cfg_ctrl #(
    parameter int KEY_OFF  = 18,
    parameter int KEY_LEN  = 197,
    parameter int ACT_W    = 625,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 4,
    parameter int DRAIN_TO = 255,
    parameter int WR_GAP   = 2
) (
    input  logic               axis_clk,
    input  logic               aresetn,
    input  logic               phv_in_valid,
    input  logic               phv_out_valid,
    output logic               stg_ready,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_sel,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ACT_W-1:0]   cfg_data,
    input  logic [KEY_LEN-1:0] cfg_mask,
    output logic [KEY_OFF-1:0] key_off_entry_in,
    output logic               key_off_entry_in_valid,
    output logic [ADDR_W-1:0]  key_off_entry_addr,
    output logic [KEY_LEN-1:0] lookup_din,
    output logic [KEY_LEN-1:0] lookup_din_mask,
    output logic [ADDR_W-1:0]  lookup_din_addr,
    output logic               lookup_din_en,
    output logic [ACT_W-1:0]   action_data_in,
    output logic               action_en,
    output logic [ADDR_W-1:0]  action_addr,
    output logic [CNT_W-1:0]   inflight_cnt,
    output logic [2:0]         err_status,
    input  logic               err_clr
);
    typedef enum logic [1:0] {IDLE, DRAIN, WRITE, GAP} state_t;

    localparam int TO_W  = $clog2(DRAIN_TO + 1);
    localparam int GAP_W = $clog2(WR_GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, next_state;
    logic [TO_W-1:0]    to_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [1:0]         sel_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ACT_W-1:0]   data_q;
    logic [KEY_LEN-1:0] mask_q;

    logic               accept, bad_sel, drain_timeout, wr_go;
    logic               stg_ready_d, cfg_ready_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [2:0]         err_set;

    assign accept        = cfg_valid && cfg_ready;
    assign bad_sel       = accept && (cfg_sel == 2'd3);
    assign drain_timeout = (state == DRAIN) && (inflight_cnt != '0)
                           && (to_cnt == TO_W'(DRAIN_TO - 1));

    // State register plus all registered outputs.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state                  <= IDLE;
            to_cnt                 <= '0;
            gap_cnt                <= '0;
            sel_q                  <= '0;
            addr_q                 <= '0;
            data_q                 <= '0;
            mask_q                 <= '0;
            stg_ready              <= 1'b1;
            cfg_ready              <= 1'b1;
            inflight_cnt           <= '0;
            err_status             <= '0;
            key_off_entry_in       <= '0;
            key_off_entry_in_valid <= 1'b0;
            key_off_entry_addr     <= '0;
            lookup_din             <= '0;
            lookup_din_mask        <= '0;
            lookup_din_addr        <= '0;
            lookup_din_en          <= 1'b0;
            action_data_in         <= '0;
            action_en              <= 1'b0;
            action_addr            <= '0;
        end else begin
            state        <= next_state;
            to_cnt       <= (state == DRAIN) ? to_cnt + 1'b1 : '0;
            gap_cnt      <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            stg_ready    <= stg_ready_d;
            cfg_ready    <= cfg_ready_d;
            inflight_cnt <= cnt_d;
            err_status   <= err_clr ? 3'b000 : (err_status | err_set);
            if (accept) begin
                sel_q  <= cfg_sel;
                addr_q <= cfg_addr;
                data_q <= cfg_data;
                mask_q <= cfg_mask;
            end
            key_off_entry_in_valid <= wr_go && (sel_q == 2'd0);
            lookup_din_en          <= wr_go && (sel_q == 2'd1);
            action_en              <= wr_go && (sel_q == 2'd2);
            // Table data/addr are only loaded for the table being written and hold otherwise.
            if (wr_go && sel_q == 2'd0) begin
                key_off_entry_in   <= data_q[KEY_OFF-1:0];
                key_off_entry_addr <= addr_q;
            end
            if (wr_go && sel_q == 2'd1) begin
                lookup_din      <= data_q[KEY_LEN-1:0];
                lookup_din_mask <= mask_q;
                lookup_din_addr <= addr_q;
            end
            if (wr_go && sel_q == 2'd2) begin
                action_data_in <= data_q;
                action_addr    <= addr_q;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept && cfg_sel != 2'd3) next_state = DRAIN;
            DRAIN: begin
                if (inflight_cnt == '0) next_state = WRITE;
                else if (drain_timeout) next_state = IDLE;
            end
            WRITE: next_state = GAP;
            GAP:   if (gap_cnt == GAP_W'(WR_GAP - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and error flags.
    always_comb begin
        stg_ready_d = (next_state == IDLE);
        cfg_ready_d = (next_state == IDLE) && !accept;
        wr_go       = (next_state == WRITE);
        cnt_d       = inflight_cnt;
        err_set     = 3'b000;
        if (phv_in_valid && !phv_out_valid) begin
            if (inflight_cnt == CNT_MAX) err_set[2] = 1'b1;
            else                         cnt_d = inflight_cnt + 1'b1;
        end else if (!phv_in_valid && phv_out_valid) begin
            if (inflight_cnt == '0) err_set[2] = 1'b1;
            else                    cnt_d = inflight_cnt - 1'b1;
        end
        if (phv_in_valid && !stg_ready) err_set[2] = 1'b1;
        if (bad_sel)                    err_set[1] = 1'b1;
        if (drain_timeout)              err_set[0] = 1'b1;
    end
endmodule

// File: tb/tb_stage_cfg_ctrl.sv
// Directed bench for stage_cfg_ctrl: a per-cycle vector table for basic flows,
// then hand-written sequences for drain, timeout, saturation and reset corners.
module tb_stage_cfg_ctrl;
    localparam int KEY_OFF  = 18;
    localparam int KEY_LEN  = 197;
    localparam int ACT_W    = 625;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = 4;
    localparam int DRAIN_TO = 8;
    localparam int WR_GAP   = 2;

    logic               axis_clk, aresetn;
    logic               phv_in_valid, phv_out_valid, stg_ready;
    logic               cfg_valid, cfg_ready;
    logic [1:0]         cfg_sel;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [ACT_W-1:0]   cfg_data;
    logic [KEY_LEN-1:0] cfg_mask;
    logic [KEY_OFF-1:0] key_off_entry_in;
    logic               key_off_entry_in_valid;
    logic [ADDR_W-1:0]  key_off_entry_addr;
    logic [KEY_LEN-1:0] lookup_din, lookup_din_mask;
    logic [ADDR_W-1:0]  lookup_din_addr;
    logic               lookup_din_en;
    logic [ACT_W-1:0]   action_data_in;
    logic               action_en;
    logic [ADDR_W-1:0]  action_addr;
    logic [CNT_W-1:0]   inflight_cnt;
    logic [2:0]         err_status;
    logic               err_clr;

    stage_cfg_ctrl #(
        .KEY_OFF(KEY_OFF), .KEY_LEN(KEY_LEN), .ACT_W(ACT_W), .ADDR_W(ADDR_W),
        .CNT_W(CNT_W), .DRAIN_TO(DRAIN_TO), .WR_GAP(WR_GAP)
    ) dut (
        .axis_clk(axis_clk), .aresetn(aresetn),
        .phv_in_valid(phv_in_valid), .phv_out_valid(phv_out_valid),
        .stg_ready(stg_ready), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_mask(cfg_mask),
        .key_off_entry_in(key_off_entry_in), .key_off_entry_in_valid(key_off_entry_in_valid),
        .key_off_entry_addr(key_off_entry_addr),
        .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask),
        .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en),
        .action_data_in(action_data_in), .action_en(action_en), .action_addr(action_addr),
        .inflight_cnt(inflight_cnt), .err_status(err_status), .err_clr(err_clr)
    );

    // Clock / reset
    initial begin
        axis_clk = 1'b0;
        forever #5 axis_clk = ~axis_clk;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       in_v, out_v, cv;
        logic [1:0] sel;
        logic [3:0] addr;
        logic       clr;
        logic       stg, crdy;
        logic [3:0] cnt;
        logic [2:0] err;
        logic [2:0] str;   // {action_en, lookup_din_en, key_off_entry_in_valid}
    } vec_t;

    vec_t vecs[$];
    logic [ACT_W-1:0]   pat_a, pat_b;
    logic [KEY_LEN-1:0] pat_m;

    function automatic vec_t mk(logic i, logic o, logic cv, logic [1:0] s, logic [3:0] a, logic c,
                                logic stg, logic crdy, logic [3:0] cnt, logic [2:0] e, logic [2:0] st);
        vec_t v;
        v.in_v = i; v.out_v = o; v.cv = cv; v.sel = s; v.addr = a; v.clr = c;
        v.stg = stg; v.crdy = crdy; v.cnt = cnt; v.err = e; v.str = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [ACT_W-1:0] act, input logic [ACT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] strobes();
        return {action_en, lookup_din_en, key_off_entry_in_valid};
    endfunction

    // Driver tasks: inputs change 1 time unit after the active edge, outputs sampled there too.
    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic idle_inputs();
        phv_in_valid = 0; phv_out_valid = 0; cfg_valid = 0; err_clr = 0;
    endtask

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        for (int i = 0; i < ACT_W; i++) begin
            pat_a[i] = a5[i % 8];
            pat_b[i] = ((i % 5) == 1);
        end
        for (int i = 0; i < KEY_LEN; i++) pat_m[i] = ((i % 3) == 0);

        aresetn = 0; idle_inputs(); cfg_sel = 0; cfg_addr = 0; cfg_data = pat_a; cfg_mask = '0;
        repeat (2) step();
        chk("reset_stg_ready", ACT_W'(stg_ready), ACT_W'(1));
        chk("reset_cfg_ready", ACT_W'(cfg_ready), ACT_W'(1));
        chk("reset_cnt", ACT_W'(inflight_cnt), '0);
        chk("reset_err", ACT_W'(err_status), '0);
        chk("reset_action_data", action_data_in, '0);
        aresetn = 1;
        #2;

        //               in out cv sel addr clr | stg crdy cnt err str
        vecs.push_back(mk(0, 0, 1, 2, 5, 0,   1, 1, 0, 3'b000, 3'b000)); // accept sel 2 at T
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000, 3'b000)); // T+1 DRAIN
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000, 3'b100)); // T+2 action write
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000, 3'b000)); // T+3 GAP
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 3'b000, 3'b000)); // T+4 GAP
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 3'b000, 3'b000)); // T+5 open
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 3'b000, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 1, 1, 3'b000, 3'b000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   1, 1, 2, 3'b000, 3'b000)); // in+out
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 1, 2, 3'b000, 3'b000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 1, 1, 3'b000, 3'b000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 1, 0, 3'b000, 3'b000)); // underflow
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 3'b100, 3'b000)); // clear
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,   1, 1, 0, 3'b000, 3'b000)); // underflow + clear
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 3'b000, 3'b000)); // clear won
        vecs.push_back(mk(0, 0, 1, 3, 1, 0,   1, 1, 0, 3'b000, 3'b000)); // bad sel at T
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 3'b010, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   1, 1, 0, 3'b010, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 0, 3'b000, 3'b000));

        foreach (vecs[k]) begin
            chk($sformatf("v%0d_stg_ready", k), ACT_W'(stg_ready), ACT_W'(vecs[k].stg));
            chk($sformatf("v%0d_cfg_ready", k), ACT_W'(cfg_ready), ACT_W'(vecs[k].crdy));
            chk($sformatf("v%0d_cnt", k), ACT_W'(inflight_cnt), ACT_W'(vecs[k].cnt));
            chk($sformatf("v%0d_err", k), ACT_W'(err_status), ACT_W'(vecs[k].err));
            chk($sformatf("v%0d_strobes", k), ACT_W'(strobes()), ACT_W'(vecs[k].str));
            phv_in_valid = vecs[k].in_v; phv_out_valid = vecs[k].out_v;
            cfg_valid = vecs[k].cv; cfg_sel = vecs[k].sel; cfg_addr = vecs[k].addr;
            err_clr = vecs[k].clr;
            step();
        end
        idle_inputs();
        chk("action_data_held", action_data_in, pat_a);
        chk("action_addr_held", ACT_W'(action_addr), ACT_W'(5));

        // Lookup write behind 3 PHVs in flight (third enters on the accept cycle).
        cfg_data = pat_b; cfg_mask = pat_m;
        phv_in_valid = 1; step(); step();
        chk("a_cnt_before", ACT_W'(inflight_cnt), ACT_W'(2));
        cfg_valid = 1; cfg_sel = 1; cfg_addr = 9;
        step();
        idle_inputs();
        chk("a_cnt_accept_phv", ACT_W'(inflight_cnt), ACT_W'(3));
        chk("a_stg_closed", ACT_W'(stg_ready), '0);
        for (int i = 0; i < 2; i++) begin
            chk("a_no_strobe_wait", ACT_W'(strobes()), '0);
            step();
        end
        phv_out_valid = 1;
        for (int i = 0; i < 3; i++) begin
            chk("a_no_strobe_drain", ACT_W'(strobes()), '0);
            step();
        end
        phv_out_valid = 0;
        chk("a_cnt_zero", ACT_W'(inflight_cnt), '0);
        chk("a_no_strobe_cnt0", ACT_W'(strobes()), '0);
        step();
        chk("a_lookup_strobe", ACT_W'(strobes()), ACT_W'(3'b010));
        chk("a_lookup_din", ACT_W'(lookup_din), ACT_W'(pat_b[KEY_LEN-1:0]));
        chk("a_lookup_mask", ACT_W'(lookup_din_mask), ACT_W'(pat_m));
        chk("a_lookup_addr", ACT_W'(lookup_din_addr), ACT_W'(9));
        step();
        chk("a_strobe_single", ACT_W'(strobes()), '0);
        chk("a_lookup_din_held", ACT_W'(lookup_din), ACT_W'(pat_b[KEY_LEN-1:0]));
        step();
        chk("a_gap_closed", ACT_W'(stg_ready), '0);
        step();
        chk("a_reopen_stg", ACT_W'(stg_ready), ACT_W'(1));
        chk("a_reopen_cfg", ACT_W'(cfg_ready), ACT_W'(1));

        // Drain timeout with one PHV stuck.
        phv_in_valid = 1; step(); phv_in_valid = 0;
        cfg_valid = 1; cfg_sel = 0; cfg_addr = 2;
        step();
        cfg_valid = 0;
        for (int i = 0; i < DRAIN_TO; i++) begin
            chk("b_stg_closed", ACT_W'(stg_ready), '0);
            chk("b_no_strobe", ACT_W'(strobes()), '0);
            chk("b_no_err_yet", ACT_W'(err_status), '0);
            step();
        end
        chk("b_timeout_err", ACT_W'(err_status), ACT_W'(3'b001));
        chk("b_timeout_stg", ACT_W'(stg_ready), ACT_W'(1));
        chk("b_timeout_cfg", ACT_W'(cfg_ready), ACT_W'(1));
        chk("b_timeout_no_strobe", ACT_W'(strobes()), '0);
        chk("b_key_off_untouched", ACT_W'(key_off_entry_in), '0);
        err_clr = 1; step(); err_clr = 0;
        chk("b_err_cleared", ACT_W'(err_status), '0);
        phv_out_valid = 1; step(); phv_out_valid = 0;
        chk("b_cnt_zero", ACT_W'(inflight_cnt), '0);

        // PHV (with a simultaneous out) while the stage is closed.
        cfg_data = pat_a; cfg_valid = 1; cfg_sel = 2; cfg_addr = 7;
        step();
        cfg_valid = 0;
        chk("d_stg_closed", ACT_W'(stg_ready), '0);
        phv_in_valid = 1; phv_out_valid = 1;
        step();
        idle_inputs();
        chk("d_err_not_ready", ACT_W'(err_status), ACT_W'(3'b100));
        chk("d_cnt_same", ACT_W'(inflight_cnt), '0);
        chk("d_action_strobe", ACT_W'(strobes()), ACT_W'(3'b100));
        chk("d_action_addr", ACT_W'(action_addr), ACT_W'(7));
        repeat (3) step();
        chk("d_reopen", ACT_W'(stg_ready), ACT_W'(1));
        err_clr = 1; step(); err_clr = 0;

        // Counter saturation.
        phv_in_valid = 1;
        repeat (15) step();
        chk("s_cnt_max", ACT_W'(inflight_cnt), ACT_W'(15));
        chk("s_err_none", ACT_W'(err_status), '0);
        step();
        phv_in_valid = 0;
        chk("s_cnt_sat", ACT_W'(inflight_cnt), ACT_W'(15));
        chk("s_err_ovf", ACT_W'(err_status), ACT_W'(3'b100));
        err_clr = 1; step(); err_clr = 0;
        phv_out_valid = 1;
        repeat (15) step();
        phv_out_valid = 0;
        chk("s_cnt_back", ACT_W'(inflight_cnt), '0);
        chk("s_err_clean", ACT_W'(err_status), '0);

        // Reset asserted during GAP.
        cfg_data = pat_b; cfg_valid = 1; cfg_sel = 0; cfg_addr = 3;
        step();
        cfg_valid = 0;
        step();
        chk("c_key_strobe", ACT_W'(strobes()), ACT_W'(3'b001));
        chk("c_key_data", ACT_W'(key_off_entry_in), ACT_W'(pat_b[KEY_OFF-1:0]));
        chk("c_key_addr", ACT_W'(key_off_entry_addr), ACT_W'(3));
        step();
        chk("c_gap_closed", ACT_W'(stg_ready), '0);
        aresetn = 0;
        #1;
        chk("c_rst_stg", ACT_W'(stg_ready), ACT_W'(1));
        chk("c_rst_cfg", ACT_W'(cfg_ready), ACT_W'(1));
        chk("c_rst_strobes", ACT_W'(strobes()), '0);
        chk("c_rst_key_data", ACT_W'(key_off_entry_in), '0);
        chk("c_rst_key_addr", ACT_W'(key_off_entry_addr), '0);
        chk("c_rst_lookup", ACT_W'(lookup_din), '0);
        chk("c_rst_action", action_data_in, '0);
        chk("c_rst_cnt", ACT_W'(inflight_cnt), '0);
        @(negedge axis_clk);
        aresetn = 1;
        step();
        chk("c_post_stg", ACT_W'(stg_ready), ACT_W'(1));
        chk("c_post_cfg", ACT_W'(cfg_ready), ACT_W'(1));
        chk("c_post_strobes", ACT_W'(strobes()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
